// File: rtl/adder_arb_pkg.sv
// Shared types for the adder pipeline arbiter: requester-ID tag and control FSM states.
package adder_arb_pkg;

    // Tag id is sized for the largest supported requester count so one type serves every build.
    localparam int NREQ_MAX = 8;
    localparam int ID_W     = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/adder_pipe_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr; ptr moves past the winner on advance.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found                          = 1'b1;
                grant[(int'(ptr) + i) % NREQ]  = 1'b1;
                grant_id                       = ID_W'((int'(ptr) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/adder_pipe_arbiter.sv
// Shares one external LAT-cycle adder among NREQ requesters with round-robin issue and tagged result steering.
// Optional ADDER_ARB_STATS_EN adds per-requester grant counters, a busy-cycle counter and a synchronous clear.
module adder_pipe_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W:0]        rsp_sum,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W:0]        add_sum,
    input  logic              flush,
    output logic              idle
`ifdef ADDER_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [NREQ*16-1:0] stat_grants,
    output logic [15:0]       stat_busy
`endif
);

    state_t          state, state_nxt;
    logic            grant_en, transfer, any_tag;
    logic [NREQ-1:0] grant, rsp_nxt;
    logic [ID_W-1:0] grant_id;
    logic [W-1:0]    op_a, op_b;
    tag_t            tags [0:LAT];

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clock    (clock),
        .reset    (reset),
        .req      (req_valid),
        .advance  (transfer),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid && !flush) state_nxt = RUN;
            RUN:     if (flush) state_nxt = DRAIN;
                     else if (!(|req_valid) && !any_tag) state_nxt = IDLE;
            DRAIN:   if (!any_tag && !flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Granting in IDLE as well lets the first request issue on the IDLE->RUN clock.
    always_comb begin
        grant_en = !reset && !flush && (state != DRAIN);
    end

    assign req_ready = grant_en ? grant : '0;
    assign transfer  = |req_ready;
    assign idle      = (state == IDLE) && !any_tag;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                op_a = req_a[i*W +: W];
                op_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        any_tag = 1'b0;
        for (int k = 0; k <= LAT; k++) any_tag = any_tag | tags[k].valid;
        for (int i = 0; i < NREQ; i++) rsp_nxt[i] = tags[LAT].valid && (tags[LAT].id == ID_W'(i));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= '0;
            rsp_sum   <= '0;
            for (int k = 0; k <= LAT; k++) tags[k] <= '0;
        end else begin
            if (transfer) begin
                add_a <= op_a;
                add_b <= op_b;
            end
            tags[0] <= '{valid: transfer, id: grant_id};
            for (int k = 1; k <= LAT; k++) tags[k] <= tags[k-1];
            rsp_valid <= rsp_nxt;
            if (tags[LAT].valid) rsp_sum <= add_sum;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] grant_cnt [NREQ];
    logic [15:0] busy_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
        end else if (stat_clr) begin
            busy_cnt <= '0;
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
        end else begin
            if (any_tag) busy_cnt <= busy_cnt + 16'd1;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = grant_cnt[g];
    end
    assign stat_busy = busy_cnt;
`endif

endmodule
